// File: rtl/morse_keyer.sv
// Morse keyer: sends one character as a keyed on/off stream at UNIT clocks per
// Morse time unit, then a trailing character or word gap, and pulses done.
module morse_keyer #(
  parameter int UNIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [2:0] len_i,
  input  logic [4:0] symbols_i,
  input  logic       word_i,
  output logic       key_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = (UNIT > 1) ? $clog2(UNIT) : 1;
  localparam logic [CW-1:0] CycLast = CW'(UNIT - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_e;

  state_e     state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0] unit_q, unit_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] len_q, len_d;
  logic [4:0] sym_q, sym_d;
  logic       word_q, word_d;
  logic       key_q, key_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [2:0] segUnits;
  logic       cycEnd;
  logic       segEnd;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      sym_q   <= '0;
      word_q  <= 1'b0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      sym_q   <= sym_d;
      word_q  <= word_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Length in units of the segment currently being timed.
  always_comb begin
    segUnits = 3'd1;
    case (state_q)
      MARK:    segUnits = sym_q[idx_q] ? 3'd3 : 3'd1;
      SPACE:   segUnits = 3'd1;
      GAP:     segUnits = word_q ? 3'd7 : 3'd3;
      default: segUnits = 3'd1;
    endcase
  end

  assign cycEnd = (cyc_q == CycLast);
  assign segEnd = cycEnd && (unit_q == segUnits - 3'd1);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    unit_d  = unit_q;
    idx_d   = idx_q;
    len_d   = len_q;
    sym_d   = sym_q;
    word_d  = word_q;
    done_d  = 1'b0;

    if (state_q == IDLE) begin
      if (load_i && (len_i != 3'd0) && (len_i <= 3'd5)) begin
        len_d   = len_i;
        sym_d   = symbols_i;
        word_d  = word_i;
        idx_d   = '0;
        cyc_d   = '0;
        unit_d  = '0;
        state_d = MARK;
      end
    end else begin
      if (cycEnd) begin
        cyc_d  = '0;
        unit_d = unit_q + 3'd1;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
      if (segEnd) begin
        unit_d = '0;
        case (state_q)
          MARK:  state_d = (idx_q < len_q - 3'd1) ? SPACE : GAP;
          SPACE: begin
            idx_d   = idx_q + 3'd1;
            state_d = MARK;
          end
          GAP: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // Outputs are registered from the next state so they align with it.
    key_d  = (state_d == MARK);
    busy_d = (state_d != IDLE);
  end

  assign key_o  = key_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Directed testbench for morse_keyer: UNIT=4 instance for the main scenarios
// and a UNIT=1 instance for the single-cycle-unit boundary.
module tb_morse_keyer;

  logic       clk;
  logic       rst, load, word;
  logic [2:0] len;
  logic [4:0] sym;
  logic       key, busy, done;

  logic       rst1, load1, word1;
  logic [2:0] len1;
  logic [4:0] sym1;
  logic       key1, busy1, done1;

  int checks = 0;
  int errors = 0;

  morse_keyer #(.UNIT(4)) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load), .len_i(len), .symbols_i(sym),
    .word_i(word), .key_o(key), .busy_o(busy), .done_o(done)
  );

  morse_keyer #(.UNIT(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .load_i(load1), .len_i(len1), .symbols_i(sym1),
    .word_i(word1), .key_o(key1), .busy_o(busy1), .done_o(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive load in cycle 0; returns at the sampling point of cycle 1.
  task automatic start_char(input logic [2:0] l, input logic [4:0] s, input logic w);
    @(negedge clk);
    len = l; sym = s; word = w; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; len = 3'd2; sym = 5'b00010; word = 1'b0;
    rst1 = 1'b1; load1 = 1'b0; len1 = 3'd0; sym1 = 5'b0; word1 = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (key !== 1'b0) begin errors++; $display("[TB] FAIL reset_key got %b want 0", key); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    load = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_prio_busy got %b want 0", busy); end
    checks++; if (key !== 1'b0) begin errors++; $display("[TB] FAIL reset_prio_key got %b want 0", key); end
    load = 1'b0; rst = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_char_a;
    logic ek, eb, ed;
    start_char(3'd2, 5'b00010, 1'b0);
    for (int c = 1; c <= 34; c++) begin
      ek = (c >= 1 && c <= 4) || (c >= 9 && c <= 20);
      eb = (c <= 32);
      ed = (c == 33);
      checks++; if (key !== ek) begin errors++; $display("[TB] FAIL a_key cyc %0d got %b want %b", c, key, ek); end
      checks++; if (busy !== eb) begin errors++; $display("[TB] FAIL a_busy cyc %0d got %b want %b", c, busy, eb); end
      checks++; if (done !== ed) begin errors++; $display("[TB] FAIL a_done cyc %0d got %b want %b", c, done, ed); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic ek, eb, ed;
    start_char(3'd1, 5'b00000, 1'b0);
    for (int c = 1; c <= 43; c++) begin
      ek = (c >= 1 && c <= 4) || (c >= 18 && c <= 29);
      eb = (c >= 1 && c <= 16) || (c >= 18 && c <= 41);
      ed = (c == 17) || (c == 42);
      checks++; if (key !== ek) begin errors++; $display("[TB] FAIL b2b_key cyc %0d got %b want %b", c, key, ek); end
      checks++; if (busy !== eb) begin errors++; $display("[TB] FAIL b2b_busy cyc %0d got %b want %b", c, busy, eb); end
      checks++; if (done !== ed) begin errors++; $display("[TB] FAIL b2b_done cyc %0d got %b want %b", c, done, ed); end
      if (c == 17) begin
        len = 3'd1; sym = 5'b00001; word = 1'b0; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_word_gap;
    logic ek, eb, ed;
    start_char(3'd5, 5'b11111, 1'b1);
    for (int c = 1; c <= 106; c++) begin
      ek = (c <= 76) && (((c - 1) % 16) < 12);
      eb = (c <= 104);
      ed = (c == 105);
      checks++; if (key !== ek) begin errors++; $display("[TB] FAIL zero_key cyc %0d got %b want %b", c, key, ek); end
      checks++; if (busy !== eb) begin errors++; $display("[TB] FAIL zero_busy cyc %0d got %b want %b", c, busy, eb); end
      checks++; if (done !== ed) begin errors++; $display("[TB] FAIL zero_done cyc %0d got %b want %b", c, done, ed); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_loads;
    logic ek, eb, ed;
    logic [2:0] badLen [2];
    badLen[0] = 3'd0;
    badLen[1] = 3'd6;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      len = badLen[k]; sym = 5'b10101; word = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_busy len %0d got %b want 0", badLen[k], busy); end
        checks++; if (key !== 1'b0) begin errors++; $display("[TB] FAIL illegal_key len %0d got %b want 0", badLen[k], key); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL illegal_done len %0d got %b want 0", badLen[k], done); end
        @(negedge clk);
      end
    end
    start_char(3'd2, 5'b00010, 1'b0);
    for (int c = 1; c <= 34; c++) begin
      ek = (c >= 1 && c <= 4) || (c >= 9 && c <= 20);
      eb = (c <= 32);
      ed = (c == 33);
      checks++; if (key !== ek) begin errors++; $display("[TB] FAIL midload_key cyc %0d got %b want %b", c, key, ek); end
      checks++; if (busy !== eb) begin errors++; $display("[TB] FAIL midload_busy cyc %0d got %b want %b", c, busy, eb); end
      checks++; if (done !== ed) begin errors++; $display("[TB] FAIL midload_done cyc %0d got %b want %b", c, done, ed); end
      if (c == 2) begin
        len = 3'd1; sym = 5'b00001; word = 1'b1; load = 1'b1;
      end else begin
        load = 1'b0;
        if (c == 3) begin
          len = 3'd5; sym = 5'b11111;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    logic ek, eb, ed;
    start_char(3'd2, 5'b00010, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    checks++; if (key !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_key got %b want 0", key); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_done got %b want 0", done); end
    start_char(3'd2, 5'b00010, 1'b0);
    for (int c = 1; c <= 34; c++) begin
      ek = (c >= 1 && c <= 4) || (c >= 9 && c <= 20);
      eb = (c <= 32);
      ed = (c == 33);
      checks++; if (key !== ek) begin errors++; $display("[TB] FAIL restart_key cyc %0d got %b want %b", c, key, ek); end
      checks++; if (busy !== eb) begin errors++; $display("[TB] FAIL restart_busy cyc %0d got %b want %b", c, busy, eb); end
      checks++; if (done !== ed) begin errors++; $display("[TB] FAIL restart_done cyc %0d got %b want %b", c, done, ed); end
      @(negedge clk);
    end
  endtask

  task automatic test_unit1;
    logic [7:0] keyPat;
    logic ek, eb, ed;
    keyPat = 8'b00011101;
    @(negedge clk);
    len1 = 3'd2; sym1 = 5'b00010; word1 = 1'b0; load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      ek = (c <= 8) ? keyPat[c-1] : 1'b0;
      eb = (c <= 8);
      ed = (c == 9);
      checks++; if (key1 !== ek) begin errors++; $display("[TB] FAIL u1_key cyc %0d got %b want %b", c, key1, ek); end
      checks++; if (busy1 !== eb) begin errors++; $display("[TB] FAIL u1_busy cyc %0d got %b want %b", c, busy1, eb); end
      checks++; if (done1 !== ed) begin errors++; $display("[TB] FAIL u1_done cyc %0d got %b want %b", c, done1, ed); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_char_a();
    test_back_to_back();
    test_word_gap();
    test_ignored_loads();
    test_reset_mid();
    test_unit1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
